// File: rtl/kypd_pkg.sv
// Shared constants and types for the PmodKYPD column scanner.
// Keymap entries are indexed by scan-image bit position (4*column + row).
package kypd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    localparam logic [3:0] KEYMAP [NUM_ROWS*NUM_COLS] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    localparam logic [4:0] CAND_NONE = 5'h00;

    typedef enum logic [1:0] {
        ST_DRIVE  = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/kypd_debounce.sv
// Scan-level debouncer: requires DEBOUNCE_SCANS identical candidates before
// committing, pulses the strobe only when a new pressed key is committed.
module kypd_debounce
    import kypd_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eval_i,
    input  logic [4:0] cand_i,
    output logic [4:0] key_code_o,
    output logic       key_strobe_o
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [4:0]    prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    comm_q, comm_d;
    logic [4:0]    code_q, code_d;
    logic          strobe_q, strobe_d;

    // Match counting and commit decision, only acted on during EVAL
    always_comb begin
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        comm_d   = comm_q;
        code_d   = code_q;
        strobe_d = 1'b0;
        if (eval_i) begin
            prev_d = cand_i;
            if (cand_i == prev_q) begin
                cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
            end else begin
                cnt_d = CNT_ONE;
            end
            if ((cnt_d == CNT_MAX) && (cand_i != comm_q)) begin
                comm_d = cand_i;
                if (cand_i[4]) begin
                    code_d   = cand_i;
                    strobe_d = 1'b1;
                end else begin
                    // Release keeps the last hex value visible
                    code_d = {1'b0, code_q[3:0]};
                end
            end else begin
                comm_d = comm_q;
            end
        end else begin
            prev_d = prev_q;
        end
    end

    // Debounce state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= CAND_NONE;
            cnt_q    <= {CW{1'b0}};
            comm_q   <= CAND_NONE;
            code_q   <= 5'h00;
            strobe_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            comm_q   <= comm_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
        end
    end

    assign key_code_o   = code_q;
    assign key_strobe_o = strobe_q;

endmodule

// File: rtl/kypd_scanner.sv
// PmodKYPD column scanner: drives one column low at a time, samples rows,
// reduces each full scan to a key candidate. Option: KYPD_GHOST_REJECT_EN.
module kypd_scanner
    import kypd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] key_code,
    output logic       key_strobe
);

    localparam int SCW = $clog2(SETTLE_CYCLES);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0] SETTLE_ZERO = {SCW{1'b0}};

    logic [3:0]                     row_s1_q, row_s2_q;
    scan_state_e                    state_q, state_d;
    logic [SCW-1:0]                 settle_q, settle_d;
    logic [1:0]                     col_idx_q, col_idx_d;
    logic [NUM_ROWS*NUM_COLS-1:0]   image_q, image_d;
    logic [3:0]                     col_q, col_d;
    logic [4:0]                     cand_s;
    logic                           eval_s;

    // Two-flop synchronizer for the asynchronous row lines (idle high)
    always_ff @(posedge clk) begin
        if (reset) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    // Scan FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DRIVE:  state_d = (settle_q == SETTLE_ZERO) ? ST_SAMPLE : ST_DRIVE;
            ST_SAMPLE: state_d = (col_idx_q == 2'd3) ? ST_EVAL : ST_DRIVE;
            ST_EVAL:   state_d = ST_DRIVE;
            default:   state_d = ST_DRIVE;
        endcase
    end

    // Per-state datapath: settle counter, column pointer, image, column drive
    always_comb begin
        settle_d  = settle_q;
        col_idx_d = col_idx_q;
        image_d   = image_q;
        col_d     = col_q;
        eval_s    = 1'b0;
        case (state_q)
            ST_DRIVE: begin
                settle_d = (settle_q == SETTLE_ZERO) ? settle_q : settle_q - 1'b1;
            end
            ST_SAMPLE: begin
                image_d[{col_idx_q, 2'b00} +: 4] = ~row_s2_q;
                settle_d = SETTLE_LOAD;
                if (col_idx_q != 2'd3) begin
                    col_idx_d = col_idx_q + 2'd1;
                    col_d     = ~(4'b0001 << (col_idx_q + 2'd1));
                end else begin
                    col_idx_d = col_idx_q;
                end
            end
            ST_EVAL: begin
                eval_s    = 1'b1;
                settle_d  = SETTLE_LOAD;
                col_idx_d = 2'd0;
                col_d     = 4'b1110;
            end
            default: begin
                settle_d  = SETTLE_LOAD;
                col_idx_d = 2'd0;
                col_d     = 4'b1110;
            end
        endcase
    end

    // Candidate reduction: the lowest set image index wins
    always_comb begin
        cand_s = CAND_NONE;
        for (int i = NUM_ROWS*NUM_COLS-1; i >= 0; i--) begin
            cand_s = image_q[i] ? {1'b1, KEYMAP[i]} : cand_s;
        end
`ifdef KYPD_GHOST_REJECT_EN
        cand_s = ($countones(image_q) > 32'sd1) ? CAND_NONE : cand_s;
`else
        cand_s = cand_s;
`endif
    end

    // Scan FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DRIVE;
            settle_q  <= SETTLE_LOAD;
            col_idx_q <= 2'd0;
            image_q   <= {(NUM_ROWS*NUM_COLS){1'b0}};
            col_q     <= 4'b1110;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            col_idx_q <= col_idx_d;
            image_q   <= image_d;
            col_q     <= col_d;
        end
    end

    kypd_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .eval_i       (eval_s),
        .cand_i       (cand_s),
        .key_code_o   (key_code),
        .key_strobe_o (key_strobe)
    );

    assign col = col_q;

endmodule
